// File: rtl/contador16_pkg.sv
// rtl/contador16_pkg.sv - shared encodings and defaults for contador16 and its checker
package contador16_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    MODO_UP   = 2'b00,
    MODO_DN1  = 2'b01,
    MODO_DN3  = 2'b10,
    MODO_LOAD = 2'b11
  } modo_e;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } chk_state_e;

endpackage

// File: rtl/contador16_paso.sv
// rtl/contador16_paso.sv - combinational single step of the counter: next value and wrap bit
module contador16_paso
  import contador16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] base_i,
  input  logic             enb_i,
  input  logic [1:0]       modo_i,
  input  logic [WIDTH-1:0] entrada_i,
  output logic [WIDTH-1:0] siguiente_o,
  output logic             wrap_o
);

  modo_e modo;
  assign modo = modo_e'(modo_i);

  always_comb begin
    siguiente_o = base_i;
    wrap_o      = 1'b0;
    if (enb_i) begin
      case (modo)
        MODO_UP: begin
          siguiente_o = base_i + WIDTH'(1);
          wrap_o      = (base_i == {WIDTH{1'b1}});
        end
        MODO_DN1: begin
          siguiente_o = base_i - WIDTH'(1);
          wrap_o      = (base_i == '0);
        end
        MODO_DN3: begin
          siguiente_o = base_i - WIDTH'(3);
          wrap_o      = (base_i < WIDTH'(3));
        end
        default: begin
          siguiente_o = entrada_i;
          wrap_o      = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/contador16_checker.sv
// rtl/contador16_checker.sv - passive golden-model observer for contador16 with error and wrap statistics
module contador16_checker
  import contador16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] entrada,
  input  logic [WIDTH-1:0] salida,
  input  logic             RCO,
  output logic             SYNC,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] RCO_CNT
);

  chk_state_e       state_q;
  logic [WIDTH-1:0] modelo_q;
  logic             rco_m_q;
  logic             err_q;
  logic             sticky_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] rco_cnt_q;

  logic             mismatch;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] paso_val;
  logic             paso_wrap;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] rco_cnt_d;

  // After a mismatch the model restarts from the observed value, so one fault counts once.
  always_comb begin
    mismatch = (state_q == ST_SYNC) && ((salida != modelo_q) || (RCO != rco_m_q));
    base     = mismatch ? salida : modelo_q;
  end

  contador16_paso #(.WIDTH(WIDTH)) u_paso (
    .base_i      (base),
    .enb_i       (ENB),
    .modo_i      (MODO),
    .entrada_i   (entrada),
    .siguiente_o (paso_val),
    .wrap_o      (paso_wrap)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    rco_cnt_d = rco_cnt_q;
    if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    if ((state_q == ST_SYNC) && RCO && (rco_cnt_q != {CNT_W{1'b1}})) begin
      rco_cnt_d = rco_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_UNSYNC;
      modelo_q  <= '0;
      rco_m_q   <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      rco_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_UNSYNC: begin
          err_q <= 1'b0;
          if (ENB && (MODO == MODO_LOAD)) begin
            modelo_q <= entrada;
            rco_m_q  <= 1'b0;
            state_q  <= ST_SYNC;
          end
        end
        default: begin
          modelo_q  <= paso_val;
          rco_m_q   <= paso_wrap;
          err_q     <= mismatch;
          sticky_q  <= sticky_q | mismatch;
          err_cnt_q <= err_cnt_d;
          rco_cnt_q <= rco_cnt_d;
        end
      endcase
    end
  end

  assign SYNC       = (state_q == ST_SYNC);
  assign ERR        = err_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = err_cnt_q;
  assign RCO_CNT    = rco_cnt_q;

endmodule

// File: tb/tb_contador16_checker.sv
// tb/tb_contador16_checker.sv - randomized self-checking bench for contador16_checker
module tb_contador16_checker;

  localparam int W    = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MOD  = 1 << W;

  logic          CLK = 1'b0;
  logic          RESET_L;
  logic          ENB;
  logic [1:0]    MODO;
  logic [W-1:0]  entrada;
  logic [W-1:0]  salida;
  logic          RCO;
  logic          SYNC;
  logic          ERR;
  logic          ERR_STICKY;
  logic [CW-1:0] ERR_CNT;
  logic [CW-1:0] RCO_CNT;

  contador16_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK        (CLK),
    .RESET_L    (RESET_L),
    .ENB        (ENB),
    .MODO       (MODO),
    .entrada    (entrada),
    .salida     (salida),
    .RCO        (RCO),
    .SYNC       (SYNC),
    .ERR        (ERR),
    .ERR_STICKY (ERR_STICKY),
    .ERR_CNT    (ERR_CNT),
    .RCO_CNT    (RCO_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  // emulated counter under observation
  int ctr_val = 0;
  bit ctr_rco = 0;

  // reference checker state
  bit r_sync, r_rco, r_err, r_sticky;
  int r_model, r_errcnt, r_rcocnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_step(input int base, input bit enb, input int modo, input int ent,
                          output int nv, output bit w);
    int t;
    nv = base;
    w  = 0;
    if (enb) begin
      case (modo)
        0: begin t = base + 1; w = (t >= MOD); nv = t % MOD; end
        1: begin t = base - 1; w = (t < 0);    nv = (t + MOD) % MOD; end
        2: begin t = base - 3; w = (t < 0);    nv = (t + MOD) % MOD; end
        default: begin nv = ent; w = 0; end
      endcase
    end
  endtask

  task automatic ref_reset();
    r_sync = 0; r_rco = 0; r_err = 0; r_sticky = 0;
    r_model = 0; r_errcnt = 0; r_rcocnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sync"},   32'(SYNC),       32'(r_sync));
    check({tag, "_err"},    32'(ERR),        32'(r_err));
    check({tag, "_sticky"}, 32'(ERR_STICKY), 32'(r_sticky));
    check({tag, "_errcnt"}, 32'(ERR_CNT),    32'(r_errcnt));
    check({tag, "_rcocnt"}, 32'(RCO_CNT),    32'(r_rcocnt));
    if (ERR) err_seen++;
  endtask

  // Starts and ends at a falling edge. fs jumps the counter to fsv; fr flips its RCO.
  task automatic cycle(input string tag, input bit enb, input int modo, input int ent,
                       input bit fs, input int fsv, input bit fr);
    int s, nv;
    bit r, nw, mis;
    if (fs) ctr_val = fsv;
    s = ctr_val;
    r = ctr_rco ^ fr;
    salida  = W'(s);
    RCO     = r;
    ENB     = enb;
    MODO    = 2'(modo);
    entrada = W'(ent);
    @(posedge CLK);
    if (!r_sync) begin
      r_err = 0;
      if (enb && modo == 3) begin
        r_model = ent; r_rco = 0; r_sync = 1;
      end
    end else begin
      mis = (s != r_model) || (r != r_rco);
      ref_step(mis ? s : r_model, enb, modo, ent, nv, nw);
      r_model = nv;
      r_rco   = nw;
      r_err   = mis;
      if (mis) begin
        r_sticky = 1;
        if (r_errcnt < CMAX) r_errcnt++;
      end
      if (r && r_rcocnt < CMAX) r_rcocnt++;
    end
    ref_step(s, enb, modo, ent, nv, nw);
    ctr_val = nv;
    ctr_rco = nw;
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2 RESET_L = 1'b0;
    #1;
    check({tag, "_rst_sync"},   32'(SYNC),       32'd0);
    check({tag, "_rst_err"},    32'(ERR),        32'd0);
    check({tag, "_rst_sticky"}, 32'(ERR_STICKY), 32'd0);
    check({tag, "_rst_errcnt"}, 32'(ERR_CNT),    32'd0);
    check({tag, "_rst_rcocnt"}, 32'(RCO_CNT),    32'd0);
    ref_reset();
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  initial begin
    RESET_L = 1'b0;
    ENB = 0; MODO = 0; entrada = '0; salida = '0; RCO = 0;
    ref_reset();
    #12;
    check("por_sync",   32'(SYNC),    32'd0);
    check("por_errcnt", 32'(ERR_CNT), 32'd0);
    @(negedge CLK);
    RESET_L = 1'b1;

    // reset then load, three correct up steps
    cycle("load", 1, 3, 'h1234, 0, 0, 0);
    check("load_sync_next", 32'(SYNC), 32'd1);
    for (int i = 0; i < 3; i++) cycle("up", 1, 0, 0, 0, 0, 0);
    check("up_errcnt", 32'(ERR_CNT), 32'd0);

    // wrap going up
    cycle("wl", 1, 3, 'hFFFE, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("wup", 1, 0, 0, 0, 0, 0);
    check("wup_rcocnt", 32'(RCO_CNT), 32'd1);
    check("wup_errcnt", 32'(ERR_CNT), 32'd0);

    // wrap going down by 3
    cycle("dl", 1, 3, 'h0001, 0, 0, 0);
    cycle("dn3", 1, 2, 0, 0, 0, 0);
    cycle("dn3h", 0, 0, 0, 0, 0, 0);
    check("dn3_rcocnt", 32'(RCO_CNT), 32'd2);
    check("dn3_errcnt", 32'(ERR_CNT), 32'd0);

    // single value fault, then clean steps from the faulty value
    mid_reset("f");
    cycle("fl", 1, 3, 'h0010, 0, 0, 0);
    err_seen = 0;
    cycle("fx", 0, 0, 0, 1, 'h00FF, 0);
    for (int i = 0; i < 4; i++) cycle("fup", 1, 0, 0, 0, 0, 0);
    check("f_pulses", 32'(err_seen),   32'd1);
    check("f_sticky", 32'(ERR_STICKY), 32'd1);
    check("f_errcnt", 32'(ERR_CNT),    32'd1);

    // wrong RCO on five non-wrapping cycles, counters saturate
    mid_reset("s");
    cycle("sl", 1, 3, 0, 0, 0, 0);
    err_seen = 0;
    for (int i = 0; i < 5; i++) cycle("srco", 1, 0, 0, 0, 0, 1);
    cycle("sh", 0, 0, 0, 0, 0, 0);
    check("s_pulses", 32'(err_seen), 32'd5);
    check("s_errcnt", 32'(ERR_CNT),  32'd3);
    check("s_rcocnt", 32'(RCO_CNT),  32'd3);

    // reset mid-run, then no comparisons until the next load
    mid_reset("m");
    err_seen = 0;
    for (int i = 0; i < 3; i++) cycle("unsync", 1, 0, 0, 1, int'($urandom_range(0, MOD - 1)), 1);
    check("m_pulses", 32'(err_seen), 32'd0);
    check("m_sync",   32'(SYNC),     32'd0);
    cycle("ml", 1, 3, 'h4321, 0, 0, 0);

    // randomized traffic with occasional faults and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) mid_reset("rnd");
      cycle("rnd", $urandom_range(0, 9) != 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, MOD - 1)), $urandom_range(0, 19) == 0,
            int'($urandom_range(0, MOD - 1)), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/contador16_checker.md
# contador16_checker

Passive observer that sits beside `contador16` in the bench and on the board: it samples the counter's control inputs and its `salida`/`RCO` outputs, runs a cycle-accurate golden model of the counter, and flags every cycle where the counter disagrees with the model. It is the consuming end of the counter interface, where the tester is the driving end. It keeps a sticky error flag, saturating error and wrap counters, and a lock/sync state so it can be attached mid-run.

## Interface
- `WIDTH`, 16, counter data width.
- `CNT_W`, 8, width of `ERR_CNT` and `RCO_CNT`. Both saturate.

- `CLK` in 1: single clock; all state changes on its rising edge.
- `RESET_L` in 1: reset, asynchronous, active-low.
- `ENB` in 1: counter enable, as driven to the counter.
- `MODO` in 2: counter mode, as driven to the counter.
- `entrada` in WIDTH: load value, as driven to the counter.
- `salida` in WIDTH: counter output under check.
- `RCO` in 1: counter ripple-carry output under check.
- `SYNC` out 1: model is locked to the counter.
- `ERR` out 1: one-cycle pulse for each mismatch detected.
- `ERR_STICKY` out 1: set on the first mismatch; cleared only by reset.
- `ERR_CNT` out CNT_W: number of mismatches, saturating at all-ones.
- `RCO_CNT` out CNT_W: number of cycles with `RCO`=1 while `SYNC`=1, saturating at all-ones.

## Operation
- Counter semantics (model), applied on each edge with `ENB`=1:
  - `MODO`=00: +1.
  - `MODO`=01: −1.
  - `MODO`=10: −3.
  - `MODO`=11: load `entrada`.
  - All arithmetic is modulo 2^WIDTH.
- `ENB`=0: the value holds and RCO is 0.
- RCO model: registered and set for exactly the cycle after a wrapping step:
  - Up: base = all-ones.
  - −1: base = 0.
  - −3: base < 3.
  - Load or hold: RCO = 0.
- States:
  - **UNSYNC** (after reset): no comparison, `ERR` stays 0. On an edge with `ENB`=1 and `MODO`=11: `modelo`←`entrada`, `rco_m`←0, go to SYNC.
  - **SYNC**: on every edge, mismatch = (`salida`≠`modelo`) OR (`RCO`≠`rco_m`).
- Base for the next-state computation: `base` = `modelo` if no mismatch, else `salida`. This resyncs the model to the observed value so one fault is counted once, not forever.
- Next-state update: `modelo`←step(base, `ENB`, `MODO`, `entrada`), and `rco_m` is set the same way.
- There is no exit from SYNC except reset.
- On a mismatch: `ERR`←1 for one cycle, `ERR_STICKY`←1, `ERR_CNT`+1 (saturating).
- In SYNC, when `RCO`=1: `RCO_CNT`+1 (saturating). Counting uses the observed `RCO`, independent of any mismatch on the same edge.

## Timing
- Reset (async, `RESET_L`=0) values: state UNSYNC; `SYNC`, `ERR`, `ERR_STICKY` = 0; `ERR_CNT`, `RCO_CNT` = 0; `modelo` and `rco_m` = 0.
- A reset asserted mid-run takes effect immediately and discards all history.
- The DUT and the model both register on edge k. The comparison at edge k+1 checks the DUT outputs produced by edge k against the model state produced by edge k.
- `ERR` is registered: it is high during the cycle after the edge on which the mismatch was sampled.
- `SYNC` rises in the cycle after the load edge. The first comparison happens one edge later.
- A load while already in SYNC is a normal step, not a resync.
- Simultaneous mismatch and saturated `ERR_CNT`: `ERR` and `ERR_STICKY` still assert, and the count stays at all-ones.
- Outputs change only on a `CLK` edge or on `RESET_L`; there is no combinational path from inputs to outputs.

## Structure
- A shared package `contador16_pkg` holds:
  - `MODO` encodings `MODO_UP`=00, `MODO_DN1`=01, `MODO_DN3`=10, `MODO_LOAD`=11.
  - Checker state encodings `ST_UNSYNC` and `ST_SYNC`.
  - Default `WIDTH`.
- One combinational sub-module, `contador16_paso`:
  - Inputs: base, `ENB`, `MODO`, `entrada`.
  - Outputs: next value and wrap bit.
  - Instantiated once in the checker; the `contador16` RTL may reuse it.

## Test plan
- **Reset then load.** Reset, then `ENB`=1, `MODO`=11, `entrada`=0x1234 for one cycle, then `MODO`=00 for 3 cycles with a correct counter. Required: `SYNC` high from the cycle after the load; `salida` 0x1235/0x1236/0x1237; `ERR` never asserts; `ERR_CNT`=0.
- **Wrap up.** Load 0xFFFE, then count up 3 times. Required: `RCO` high for the single cycle where `salida`=0x0000; `RCO_CNT`=1; no `ERR`.
- **Wrap down by 3.** Load 0x0001, then `MODO`=10. Required: the next `salida`=0xFFFE with `RCO`=1, matching the model; `ERR_CNT`=0.
- **Fault injection.** Force `salida` to 0x00FF for one cycle while the model holds 0x0010. Required: `ERR` pulses exactly once; `ERR_STICKY`=1; `ERR_CNT`=1; subsequent steps from 0x00FF produce no further errors.
- **Wrong RCO and saturation.** With `CNT_W`=2, force `RCO`=1 on 5 non-wrapping cycles. Required: `ERR_CNT` saturates at 3; `ERR` pulses 5 times; `RCO_CNT` saturates at 3.
- **Reset mid-run.** Assert `RESET_L`=0 between edges while in SYNC with `ERR_STICKY`=1. Required: all outputs are 0 immediately; the checker is in UNSYNC; no comparisons occur until the next load.
